// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking entry gate controller.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        PASS,
        LOCKED
    } gate_state_t;

    // Bits needed to hold every occupancy value from 0 up to capacity inclusive.
    function automatic int occ_width(input int capacity);
        return $clog2(capacity + 1);
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Signal bundle between the keypad/sensor front end, the lane controller and the gate actuator.
interface parking_gate_ctrl_if #(
    parameter int PSWD_W   = 8,
    parameter int CAPACITY = 8
);
    localparam int OCC_W = parking_pkg::occ_width(CAPACITY);

    logic              fr_sens;
    logic              bk_sens;
    logic [PSWD_W-1:0] pswd;
    logic              pswd_vld;
    logic              car_exit;
    logic              gate;
    logic              grant;
    logic              deny;
    logic              alarm;
    logic              full;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output fr_sens, bk_sens, pswd, pswd_vld, car_exit,
        input  gate, grant, deny, alarm, full, occupancy
    );

    modport slave (
        input  fr_sens, bk_sens, pswd, pswd_vld, car_exit,
        output gate, grant, deny, alarm, full, occupancy
    );

endinterface

// File: rtl/parking_gate_ctrl_occ_counter.sv
// Saturating occupancy counter; full is registered alongside the count so both move together.
module occ_counter
    import parking_pkg::*;
#(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = occ_width(CAPACITY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic [CNT_W-1:0] count_d;

    // An arrival and a departure in the same cycle cancel out.
    always_comb begin
        count_d = count;
        if (inc && !dec && count != CNT_W'(CAPACITY)) begin
            count_d = count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count_d = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            full  <= 1'b0;
        end else begin
            count <= count_d;
            full  <= (count_d == CNT_W'(CAPACITY));
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry lane controller: password check, bounded gate opening, wrong-password lockout, occupancy.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int PSWD_W      = 8,
    parameter int PSWD        = 194,
    parameter int MAX_TRIES   = 3,
    parameter int OPEN_CYCLES = 16,
    parameter int LOCK_CYCLES = 32,
    parameter int CAPACITY    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    parking_gate_ctrl_if.slave  bus
);

    localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    gate_state_t      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             grant_d, deny_d, gate_d, alarm_d;
    logic             grant_q, deny_q, gate_q, alarm_q;
    logic             occ_inc;

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tries_d = tries_q;
        grant_d = 1'b0;
        deny_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.pswd_vld && bus.fr_sens) begin
                    if (bus.full) begin
                        deny_d = 1'b1;
                    end else if (bus.pswd == PSWD_W'(PSWD)) begin
                        grant_d = 1'b1;
                        tries_d = '0;
                        timer_d = TMR_W'(OPEN_CYCLES - 1);
                        state_d = OPEN;
                    end else begin
                        deny_d = 1'b1;
                        if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                            tries_d = '0;
                            timer_d = TMR_W'(LOCK_CYCLES - 1);
                            state_d = LOCKED;
                        end else begin
                            tries_d = tries_q + 1'b1;
                        end
                    end
                end
            end
            OPEN: begin
                if (bus.bk_sens) begin
                    state_d = PASS;
                end else if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            PASS: begin
                if (!bus.bk_sens) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        gate_d  = (state_d == OPEN) || (state_d == PASS);
        alarm_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            tries_q <= '0;
            grant_q <= 1'b0;
            deny_q  <= 1'b0;
            gate_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tries_q <= tries_d;
            grant_q <= grant_d;
            deny_q  <= deny_d;
            gate_q  <= gate_d;
            alarm_q <= alarm_d;
        end
    end

    // A car counts as parked once it has cleared the back sensor.
    assign occ_inc = (state_q == PASS) && !bus.bk_sens;

    occ_counter #(
        .CAPACITY (CAPACITY)
    ) u_occ (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (occ_inc),
        .dec   (bus.car_exit),
        .count (bus.occupancy),
        .full  (bus.full)
    );

    assign bus.gate  = gate_q;
    assign bus.grant = grant_q;
    assign bus.deny  = deny_q;
    assign bus.alarm = alarm_q;

endmodule
